// File: rtl/program_memory_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | program_memory_loader: BIP instruction memory, UART loader and CPU control |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module program_memory_loader #(
  parameter int PC_CANT_BITS  = 11,
  parameter int OPCODE_LENGTH = 5,
  parameter int HLT_OPCODE    = 0
) (
  input  logic                                    i_clock,
  input  logic                                    i_reset,
  input  logic [7:0]                              i_rx_data,
  input  logic                                    i_rx_valid,
  output logic [7:0]                              o_tx_data,
  output logic                                    o_tx_valid,
  input  logic                                    i_tx_ready,
  input  logic [PC_CANT_BITS-1:0]                 i_fetch_addr,
  output logic [OPCODE_LENGTH+PC_CANT_BITS-1:0]   o_instr,
  output logic                                    o_soft_reset,
  output logic                                    o_halted
);

  localparam int WORD_W = OPCODE_LENGTH + PC_CANT_BITS;
  localparam int DEPTH  = 2**PC_CANT_BITS;

  localparam logic [7:0]               c_CMD_LOAD = 8'h4C;
  localparam logic [7:0]               c_CMD_RUN  = 8'h52;
  localparam logic [7:0]               c_CMD_STOP = 8'h53;
  localparam logic [7:0]               c_ACK      = 8'h06;
  localparam logic [7:0]               c_NAK      = 8'h15;
  localparam logic [7:0]               c_HLT_RSP  = 8'h48;
  localparam logic [16:0]              c_DEPTH    = 17'(DEPTH);
  localparam logic [OPCODE_LENGTH-1:0] c_HLT      = OPCODE_LENGTH'(HLT_OPCODE);
  localparam logic [PC_CANT_BITS:0]    c_ONE      = (PC_CANT_BITS+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_HI = 3'd1,
    S_CNT_LO = 3'd2,
    S_W_HI   = 3'd3,
    S_W_LO   = 3'd4,
    S_RUN    = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [WORD_W-1:0]       r_mem [DEPTH];
  logic [7:0]              r_cnt_hi;
  logic [7:0]              r_word_hi;
  logic [PC_CANT_BITS:0]   r_count;
  logic [PC_CANT_BITS:0]   r_waddr;
  logic                    r_soft_reset;
  logic                    r_halted;
  logic                    r_tx_valid;
  logic [7:0]              r_tx_data;

  logic [15:0]             w_count;
  logic                    w_count_bad;
  logic [PC_CANT_BITS:0]   w_waddr_inc;
  logic                    w_last_word;
  logic                    w_is_hlt;
  logic                    w_write;
  logic                    w_soft_nxt;
  logic                    w_halted_nxt;
  logic                    w_resp;
  logic [7:0]              w_resp_data;

  assign w_count     = {r_cnt_hi, i_rx_data};
  assign w_count_bad = (w_count == 16'd0) || ({1'b0, w_count} > c_DEPTH);
  assign w_waddr_inc = r_waddr + c_ONE;
  assign w_last_word = (w_waddr_inc == r_count);
  assign w_is_hlt    = (o_instr[WORD_W-1 -: OPCODE_LENGTH] == c_HLT);
  assign w_write     = (r_state == S_W_LO) && i_rx_valid;

  assign o_instr      = r_mem[i_fetch_addr];
  assign o_soft_reset = r_soft_reset;
  assign o_halted     = r_halted;
  assign o_tx_valid   = r_tx_valid;
  assign o_tx_data    = r_tx_data;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_soft_reset <= 1'b1;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_soft_reset <= w_soft_nxt;
      r_halted     <= w_halted_nxt;
    end
  end

  // Commands are only decoded in IDLE/RUN/HALT and always win over a halt detect.
  always_comb begin
    w_state_nxt  = r_state;
    w_soft_nxt   = r_soft_reset;
    w_halted_nxt = r_halted;
    w_resp       = 1'b0;
    w_resp_data  = r_tx_data;
    case (r_state)
      S_IDLE, S_RUN, S_HALT: begin
        if (i_rx_valid && (i_rx_data == c_CMD_LOAD)) begin
          w_state_nxt  = S_CNT_HI;
          w_soft_nxt   = 1'b1;
          w_halted_nxt = 1'b0;
        end else if (i_rx_valid && (i_rx_data == c_CMD_RUN)) begin
          w_state_nxt  = S_RUN;
          w_soft_nxt   = 1'b0;
          w_halted_nxt = 1'b0;
          w_resp       = 1'b1;
          w_resp_data  = c_ACK;
        end else if (i_rx_valid && (i_rx_data == c_CMD_STOP)) begin
          w_state_nxt  = S_IDLE;
          w_soft_nxt   = 1'b1;
          w_resp       = 1'b1;
          w_resp_data  = c_ACK;
        end else if ((r_state == S_RUN) && w_is_hlt) begin
          w_state_nxt  = S_HALT;
          w_soft_nxt   = 1'b1;
          w_halted_nxt = 1'b1;
          w_resp       = 1'b1;
          w_resp_data  = c_HLT_RSP;
        end
      end
      S_CNT_HI: begin
        if (i_rx_valid) w_state_nxt = S_CNT_LO;
      end
      S_CNT_LO: begin
        if (i_rx_valid) begin
          if (w_count_bad) begin
            w_state_nxt = S_IDLE;
            w_resp      = 1'b1;
            w_resp_data = c_NAK;
          end else begin
            w_state_nxt = S_W_HI;
          end
        end
      end
      S_W_HI: begin
        if (i_rx_valid) w_state_nxt = S_W_LO;
      end
      S_W_LO: begin
        if (i_rx_valid) begin
          if (w_last_word) begin
            w_state_nxt = S_IDLE;
            w_resp      = 1'b1;
            w_resp_data = c_ACK;
          end else begin
            w_state_nxt = S_W_HI;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt_hi  <= 8'h00;
      r_word_hi <= 8'h00;
      r_count   <= '0;
      r_waddr   <= '0;
    end else if (i_rx_valid) begin
      case (r_state)
        S_CNT_HI: r_cnt_hi <= i_rx_data;
        S_CNT_LO: begin
          r_count <= w_count[PC_CANT_BITS:0];
          r_waddr <= '0;
        end
        S_W_HI:   r_word_hi <= i_rx_data;
        S_W_LO:   r_waddr   <= w_waddr_inc;
        default:  ;
      endcase
    end
  end

  // Memory has no reset so a reset during a load keeps the words already written.
  always_ff @(posedge i_clock) begin
    if (w_write) r_mem[r_waddr[PC_CANT_BITS-1:0]] <= WORD_W'({r_word_hi, i_rx_data});
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else if (w_resp) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= w_resp_data;
    end else if (r_tx_valid && i_tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_memory_loader.sv
`default_nettype none
// Bench for program_memory_loader: randomized byte stream against a byte-level model,
// tx responses checked by a queue-based scoreboard.
module tb_program_memory_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [10:0] fetch_addr;
  logic [15:0] instr;
  logic        soft_reset;
  logic        halted;

  program_memory_loader dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_tx_data    (tx_data),
    .o_tx_valid   (tx_valid),
    .i_tx_ready   (tx_ready),
    .i_fetch_addr (fetch_addr),
    .o_instr      (instr),
    .o_soft_reset (soft_reset),
    .o_halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_q [$];
  logic        hold = 1'b0;

  // Model: mode 0 idle, 1 run, 2 halt, 3 loading (byte-indexed).
  int          m_mode = 0;
  int          m_ldbytes = 0;
  int          m_n = 0;
  logic [7:0]  m_nhi = 8'h00;
  logic [7:0]  m_hi = 8'h00;
  logic        m_soft = 1'b1;
  logic        m_halted = 1'b0;
  logic [15:0] m_mem [2048];
  bit          m_known [2048];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic void push_resp(logic [7:0] b);
    if (hold) exp_q.delete();
    exp_q.push_back(b);
  endfunction

  function automatic void model_edge(logic v, logic [7:0] d);
    int k;
    if (m_mode == 3) begin
      if (v) begin
        if (m_ldbytes == 0) begin
          m_nhi = d;
        end else if (m_ldbytes == 1) begin
          m_n = int'(m_nhi) * 256 + int'(d);
          if (m_n == 0 || m_n > 2048) begin
            push_resp(8'h15);
            m_mode = 0;
          end
        end else begin
          k = m_ldbytes - 2;
          if (k % 2 == 0) begin
            m_hi = d;
          end else begin
            m_mem[k/2] = {m_hi, d};
            m_known[k/2] = 1'b1;
            if (k/2 == m_n - 1) begin
              push_resp(8'h06);
              m_mode = 0;
            end
          end
        end
        m_ldbytes++;
      end
    end else if (v && d == 8'h4C) begin
      m_mode = 3; m_ldbytes = 0; m_soft = 1'b1; m_halted = 1'b0;
    end else if (v && d == 8'h52) begin
      m_mode = 1; m_soft = 1'b0; m_halted = 1'b0; push_resp(8'h06);
    end else if (v && d == 8'h53) begin
      m_mode = 0; m_soft = 1'b1; push_resp(8'h06);
    end else if (m_mode == 1) begin
      if (!m_known[fetch_addr]) begin
        errors++;
        $display("FAIL model_fetch_unknown addr=%0h", fetch_addr);
      end else if (m_mem[fetch_addr][15:11] == 5'd0) begin
        m_mode = 2; m_halted = 1'b1; m_soft = 1'b1; push_resp(8'h48);
      end
    end
  endfunction

  // Scoreboard monitor: a byte is consumed on the edge after valid&&ready is seen here.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected actual=%02h expected=none", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL tx_byte actual=%02h expected=%02h", tx_data, e);
        end
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    model_edge(v, d);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk("soft_reset", 32'(soft_reset), 32'(m_soft));
    chk("halted", 32'(halted), 32'(m_halted));
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic chk_instr(input logic [10:0] a);
    fetch_addr = a;
    #2;
    if (m_known[a]) chk("instr", 32'(instr), 32'(m_mem[a]));
    step(1'b0, 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, 8'h00);
    idle(1);
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic send_word(input logic [15:0] w);
    send(w[15:8]);
    send(w[7:0]);
  endtask

  initial begin
    int n;
    int hk;
    logic [15:0] w;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    tx_ready   = 1'b1;
    fetch_addr = '0;
    rst_n      = 1'b0;
    for (int i = 0; i < 2048; i++) m_known[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_soft_reset", 32'(soft_reset), 1);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic load of two words
    send(8'h4C); send(8'h00); send(8'h02);
    send_word(16'h0805); send_word(16'h1007);
    drain();
    chk_instr(0);
    chk_instr(1);

    // Run, then combinational fetch
    fetch_addr = 11'd1;
    send(8'h52);
    chk("run_soft_reset", 32'(soft_reset), 0);
    fetch_addr = 11'd1;
    #1;
    chk("run_instr_same_cycle", 32'(instr), 32'h1007);
    idle(2);
    send(8'h53);
    drain();

    // Halt on fetched HLT word
    send(8'h4C); send(8'h00); send(8'h03);
    send_word(16'h0805); send_word(16'h1007); send_word(16'h0000);
    drain();
    fetch_addr = 11'd0;
    send(8'h52);
    idle(1);
    fetch_addr = 11'd1;
    idle(1);
    fetch_addr = 11'd2;
    idle(1);
    chk("halt_flag", 32'(halted), 1);
    chk("halt_soft_reset", 32'(soft_reset), 1);
    drain();

    // Command wins over a simultaneous halt; a data byte does not
    fetch_addr = 11'd2;
    send(8'h52);
    send(8'h53);
    chk("cmd_priority_halted", 32'(halted), 0);
    drain();
    send(8'h52);
    send(8'h00);
    chk("noise_with_halt", 32'(halted), 1);
    drain();

    // Invalid counts
    send(8'h4C); send(8'h08); send(8'h01);
    drain();
    chk_instr(0); chk_instr(1); chk_instr(2);
    send(8'h4C); send(8'h00); send(8'h00);
    drain();

    // Back-pressure: latest response wins
    hold = 1'b1;
    tx_ready = 1'b0;
    send(8'h53);
    chk("hold_first_valid", 32'(tx_valid), 1);
    chk("hold_first_data", 32'(tx_data), 32'h06);
    send(8'h4C); send(8'h00); send(8'h00);
    chk("hold_second_valid", 32'(tx_valid), 1);
    chk("hold_second_data", 32'(tx_data), 32'h15);
    idle(2);
    tx_ready = 1'b1;
    hold = 1'b0;
    idle(1);
    chk("hold_single_byte", 32'(tx_valid), 0);
    drain();

    // Asynchronous reset in the middle of a load
    send(8'h4C); send(8'h00); send(8'h03);
    send_word(16'h0ABC);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_soft_reset", 32'(soft_reset), 1);
    chk("mid_rst_tx_valid", 32'(tx_valid), 0);
    m_mode = 0; m_soft = 1'b1; m_halted = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_instr(0);
    send(8'h53);
    drain();

    // Full-depth load: 2048 words, no wrap
    send(8'h4C); send(8'h08); send(8'h00);
    for (int i = 0; i < 2048; i++) send_word(16'($urandom));
    drain();
    chk_instr(0); chk_instr(1); chk_instr(11'd1024); chk_instr(11'd2047);

    // Randomized load / run rounds
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(2, 8);
      hk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : -1;
      send(8'h4C); send(8'h00); send(8'(n));
      for (int i = 0; i < n; i++) begin
        w = {5'($urandom_range(1, 31)), 11'($urandom)};
        if (i == hk) w[15:11] = 5'd0;
        send_word(w);
      end
      drain();
      for (int i = 0; i < 3; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'h4C || b == 8'h52 || b == 8'h53) b = 8'h00;
        step($urandom_range(0, 1) == 1, b);
      end
      fetch_addr = 11'd0;
      send(8'h52);
      for (int c = 0; c < 12; c++) begin
        fetch_addr = 11'($urandom_range(0, n - 1));
        if ($urandom_range(0, 9) == 0) send(8'h53);
        else step(1'b0, 8'h00);
      end
      send(8'h53);
      drain();
      for (int i = 0; i < n; i++) chk_instr(11'(i));
    end

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
